// File: rtl/alu_pkg.sv
// Shared opcode/state encodings for the pipelined ALU and its sequential multiplier.
package alu_pkg;
    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_SUB = 3'b010,
        OP_ADD = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } alu_op_e;

    typedef enum logic {
        IDLE    = 1'b0,
        MUL_RUN = 1'b1
    } alu_state_e;
endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add unsigned multiplier: one multiplier bit per cycle, WIDTH cycles per product.
// prod is the accumulator value after the current step, so it is final while done is high.
module alu_mul_seq #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] prod
);
    localparam int CW = $clog2(WIDTH);

    logic               run;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;

    assign prod = acc + (mplier[0] ? mcand : '0);
    assign done = run && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run    <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (start) begin
            run    <= 1'b1;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
        end else if (run) begin
            acc    <= prod;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (done) run <= 1'b0;
        end
    end
endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes; MUL runs through alu_mul_seq over WIDTH cycles.
// Optional signed-overflow output enabled by defining ALU_PIPE_OVF_EN.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_W-1:0]    op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] res,
    output logic               carry,
    output logic               zero,
    output logic               busy
`ifdef ALU_PIPE_OVF_EN
    ,
    output logic               ovf
`endif
);
    localparam int SHW = $clog2(WIDTH);

    alu_state_e         state;
    alu_op_e            op_e;
    logic               accept;
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;
    logic [2*WIDTH-1:0] alu_res;
    logic               alu_carry;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [SHW-1:0]     sh;

    assign op_e      = alu_op_e'(op);
    assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (op_e == OP_MUL);

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mul_start),
        .a     (a),
        .b     (b),
        .done  (mul_done),
        .prod  (mul_prod)
    );

    // Shifts by >= WIDTH (non power-of-two WIDTH only) drop every bit and yield 0.
    always_comb begin
        sum       = {1'b0, a} + {1'b0, b};
        diff      = {1'b0, a} - {1'b0, b};
        sh        = b[SHW-1:0];
        alu_res   = '0;
        alu_carry = 1'b0;
        unique case (op_e)
            OP_AND: alu_res[WIDTH-1:0] = a & b;
            OP_OR:  alu_res[WIDTH-1:0] = a | b;
            OP_XOR: alu_res[WIDTH-1:0] = a ^ b;
            OP_SHL: alu_res[WIDTH-1:0] = a << sh;
            OP_SHR: alu_res[WIDTH-1:0] = a >> sh;
            OP_ADD: begin
                alu_res[WIDTH:0] = sum;
                alu_carry        = sum[WIDTH];
            end
            OP_SUB: begin
                alu_res[WIDTH:0] = diff;
                alu_carry        = diff[WIDTH];
            end
            OP_MUL: alu_res = '0;
        endcase
    end

`ifdef ALU_PIPE_OVF_EN
    logic alu_ovf;
    always_comb begin
        alu_ovf = 1'b0;
        if (op_e == OP_ADD)
            alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        else if (op_e == OP_SUB)
            alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            res       <= '0;
            carry     <= 1'b0;
            zero      <= 1'b0;
            busy      <= 1'b0;
`ifdef ALU_PIPE_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (out_valid && out_ready) out_valid <= 1'b0;
                    if (accept) begin
                        if (op_e == OP_MUL) begin
                            state <= MUL_RUN;
                            busy  <= 1'b1;
                        end else begin
                            res       <= alu_res;
                            carry     <= alu_carry;
                            zero      <= (alu_res == '0);
                            out_valid <= 1'b1;
`ifdef ALU_PIPE_OVF_EN
                            ovf       <= alu_ovf;
`endif
                        end
                    end
                end
                MUL_RUN: begin
                    // out_valid is already low here: MUL is only accepted once the slot is free.
                    if (mul_done) begin
                        res       <= mul_prod;
                        carry     <= 1'b0;
                        zero      <= (mul_prod == '0);
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
`ifdef ALU_PIPE_OVF_EN
                        ovf       <= 1'b0;
`endif
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=4): direct checks per scenario plus a result scoreboard.
module tb_alu_pipe;
    import alu_pkg::*;

    localparam int W   = 4;
    localparam int SHW = $clog2(W);

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [2:0]     op = '0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [2*W-1:0] res;
    logic           carry;
    logic           zero;
    logic           busy;
`ifdef ALU_PIPE_OVF_EN
    logic           ovf;
`endif

    typedef struct {
        logic [2*W-1:0] res;
        logic           carry;
        logic           zero;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .carry     (carry),
        .zero      (zero),
        .busy      (busy)
`ifdef ALU_PIPE_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        longint xi = x, yi = y, r = 0;
        longint mw  = (longint'(1) << W) - 1;
        longint mw1 = (longint'(1) << (W + 1)) - 1;
        longint s   = yi & ((longint'(1) << SHW) - 1);
        exp_t e;
        case (o)
            3'b000: r = xi & yi;
            3'b001: r = xi | yi;
            3'b010: r = (xi - yi) & mw1;
            3'b011: r = xi + yi;
            3'b100: r = xi ^ yi;
            3'b101: r = (xi << s) & mw;
            3'b110: r = xi >> s;
            default: r = xi * yi;
        endcase
        e.res   = r[2*W-1:0];
        e.carry = (o == 3'b010 || o == 3'b011) ? r[W] : 1'b0;
        e.zero  = (r == 0);
        return e;
    endfunction

    // Scoreboard: every delivered result is popped and compared.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: got res=%h with no result pending", res);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (res !== e.res || carry !== e.carry || zero !== e.zero) begin
                    n_err++;
                    $display("FAIL sb_result: got res=%h c=%b z=%b, want res=%h c=%b z=%b",
                             res, carry, zero, e.res, e.carry, e.zero);
                end
            end
        end
    end

    // Present an op, wait (bounded) until it is accepted, push its expectation.
    task automatic do_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        int t = 0;
        in_valid = 1'b1; op = o; a = x; b = y;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1; t++;
        end
        if (!in_ready) begin
            n_cmp++; n_err++;
            $display("FAIL accept_timeout: in_ready=%b want 1", in_ready);
        end
        q.push_back(model(o, x, y));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({out_valid, res, carry, zero, busy} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got v=%b res=%h c=%b z=%b busy=%b want all 0",
                     out_valid, res, carry, zero, busy);
        end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_add();
        do_op(OP_ADD, 4'd9, 4'd8);
        n_cmp++;
        if (out_valid !== 1'b1 || res !== 8'h11 || carry !== 1'b1 || zero !== 1'b0) begin
            n_err++;
            $display("FAIL add_9_8: got v=%b res=%h c=%b z=%b want v=1 res=11 c=1 z=0",
                     out_valid, res, carry, zero);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL add_one_cycle: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_sub();
        do_op(OP_SUB, 4'd3, 4'd5);
        n_cmp++;
        if (res !== 8'h1E || carry !== 1'b1) begin
            n_err++; $display("FAIL sub_borrow: got res=%h c=%b want 1e c=1", res, carry);
        end
        do_op(OP_SUB, 4'd5, 4'd5);
        n_cmp++;
        if (res !== 8'h00 || zero !== 1'b1 || carry !== 1'b0) begin
            n_err++; $display("FAIL sub_zero: got res=%h z=%b c=%b want 00 z=1 c=0", res, zero, carry);
        end
    endtask

    task automatic test_mul();
        do_op(OP_MUL, 4'd15, 4'd15);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL mul_busy[%0d]: busy=%b in_ready=%b out_valid=%b want 1 0 0",
                         i, busy, in_ready, out_valid);
            end
            if (i < 3) begin
                in_valid = 1'b1; op = OP_ADD; a = 4'd1; b = 4'd1;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b1 || res !== 8'hE1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL mul_15_15: got v=%b res=%h busy=%b want v=1 res=e1 busy=0", out_valid, res, busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        do_op(OP_ADD, 4'd1, 4'd2);
        in_valid = 1'b1; op = OP_OR; a = 4'd5; b = 4'd3;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || res !== 8'h03) begin
                n_err++;
                $display("FAIL hold[%0d]: in_ready=%b v=%b res=%h want 0 1 03", i, in_ready, out_valid, res);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL same_edge_ready: in_ready=%b want 1", in_ready);
        end
        q.push_back(model(OP_OR, 4'd5, 4'd3));
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || res !== 8'h07) begin
            n_err++; $display("FAIL same_edge_accept: v=%b res=%h want 1 07", out_valid, res);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_shift_xor();
        do_op(OP_SHL, 4'hB, 4'd1);
        n_cmp++;
        if (res !== 8'h06) begin n_err++; $display("FAIL shl: got %h want 06", res); end
        do_op(OP_SHR, 4'hB, 4'd2);
        n_cmp++;
        if (res !== 8'h02) begin n_err++; $display("FAIL shr: got %h want 02", res); end
        do_op(OP_XOR, 4'hA, 4'hF);
        n_cmp++;
        if (res !== 8'h05) begin n_err++; $display("FAIL xor: got %h want 05", res); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++) begin
            logic [2:0]   o;
            logic [W-1:0] x, y;
            o = 3'($urandom_range(0, 6));
            x = W'($urandom);
            y = W'($urandom);
            in_valid = 1'b1; op = o; a = x; b = y;
            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_err++; $display("FAIL b2b_ready[%0d]: in_ready=%b want 1", i, in_ready);
            end
            q.push_back(model(o, x, y));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) do_op(OP_MUL, W'($urandom), W'($urandom));
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_mul();
        do_op(OP_MUL, 4'd7, 4'd6);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL abort_now: v=%b busy=%b want 0 0", out_valid, busy);
        end
        q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                n_err++; $display("FAIL abort_stale[%0d]: v=%b busy=%b want 0 0", i, out_valid, busy);
            end
        end
        do_op(OP_ADD, 4'd5, 4'd5);
        n_cmp++;
        if (res !== 8'h0A) begin n_err++; $display("FAIL after_abort: res=%h want 0a", res); end
    endtask

`ifdef ALU_PIPE_OVF_EN
    task automatic test_ovf();
        do_op(OP_ADD, 4'd7, 4'd1);
        n_cmp++;
        if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_add: ovf=%b want 1", ovf); end
        do_op(OP_SUB, 4'd3, 4'd1);
        n_cmp++;
        if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_sub: ovf=%b want 0", ovf); end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_backpressure();
        test_shift_xor();
        test_back_to_back();
        test_reset_mid_mul();
`ifdef ALU_PIPE_OVF_EN
        test_ovf();
`endif
        for (int i = 0; i < 20 && q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        n_cmp++;
        if (q.size() != 0) begin
            n_err++; $display("FAIL drain: %0d results still pending, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered successor of the team's 4-bit combinational ALU.
- Accepts operand pairs through a valid/ready input handshake and returns registered results through a valid/ready output handshake.
- Adds XOR, shift and iterative multiply operations, plus status flags.
- Sits between the operand-fetch logic and the result writeback in the datapath experiments.

Parameters:
- WIDTH, 4, operand width in bits (minimum 2).
- SHW, $clog2(WIDTH), width of shift amount taken from b[SHW-1:0] (derived localparam, not overridable).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair and opcode are valid
- in_ready  out  1  block can accept an operation this cycle
- op  in  3  opcode
- a  in  WIDTH  operand A, unsigned
- b  in  WIDTH  operand B, unsigned
- out_valid  out  1  result is valid
- out_ready  in  1  consumer takes the result this cycle
- res  out  2*WIDTH  result, zero-extended
- carry  out  1  carry/borrow for ADD/SUB, 0 for other ops
- zero  out  1  res == 0
- busy  out  1  multiply iteration in progress

Behaviour:
- Reset (asynchronous, rst_n low): state=IDLE, out_valid=0, res=0, carry=0, zero=0, busy=0, iteration counter=0. in_ready is combinational and reads 1 after reset.
- Opcode encoding:
  - 000 AND
  - 001 OR
  - 010 SUB
  - 011 ADD
  - 100 XOR
  - 101 SHL: a << b[SHW-1:0]
  - 110 SHR (logical): a >> b[SHW-1:0]
  - 111 MUL (unsigned)
- Width rules:
  - AND/OR/XOR/SHR: WIDTH-bit result.
  - ADD: {0,a}+{0,b} in WIDTH+1 bits.
  - SUB: {0,a}-{0,b} mod 2^(WIDTH+1); bit WIDTH is the borrow.
  - SHL: WIDTH-bit result; bits shifted out are lost.
  - MUL: full 2*WIDTH product.
  - All results are zero-extended to 2*WIDTH.
  - carry = res[WIDTH] for ADD/SUB only.
- Handshake:
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - Accept on in_valid && in_ready.
  - out_valid holds until out_ready. res, carry and zero are stable while out_valid && !out_ready.
- States:
  - IDLE: accept non-MUL -> result registered at the next edge, out_valid=1 on that edge (latency 1), stays IDLE. Accept MUL -> MUL_RUN, counter=0, busy=1.
  - MUL_RUN: shift-add one bit of b per cycle. After WIDTH cycles, load res, set out_valid, clear busy, go to IDLE. Latency WIDTH+1 cycles from accept. in_ready=0 throughout.
- Back-to-back: a new op may be accepted on the same edge the old result is taken by out_ready (full throughput of 1/cycle for non-MUL ops).
- Boundaries:
  - Shift amount >= WIDTH cannot occur for power-of-two WIDTH. Otherwise it yields 0.
  - SUB with a<b wraps with borrow=1.
  - in_valid while busy is ignored; no stall of operand capture is needed because operands are latched at accept.
  - rst_n asserted mid-MUL aborts the operation; no result is produced.

Optional Feature:
- Macro ALU_PIPE_OVF_EN.
- Defined: adds output port ovf (1 bit), the signed two's-complement overflow for ADD/SUB on WIDTH-bit operands, 0 for other ops. Registered with res, reset 0.
- Undefined: no ovf port and no overflow logic.

Decomposition:
- Package alu_pkg: opcode enum alu_op_e (values above), state enum (IDLE, MUL_RUN), localparam OP_W=3.
- Sub-module alu_mul_seq: iterative shift-add multiplier with start/done, parametrised by WIDTH. Instantiated once. Top keeps the FSM, handshake and single-cycle ops.

Test Plan:
- Reset release, WIDTH=4, op=ADD a=9 b=8, out_ready=1 -> next cycle res=0x11, carry=1, zero=0, out_valid=1 for one cycle.
- op=SUB a=3 b=5 -> res=0x1E, carry=1. op=SUB a=5 b=5 -> res=0, zero=1, carry=0.
- op=MUL a=15 b=15 -> busy=1 and in_ready=0 for 4 cycles, in_valid pulses ignored, then res=0xE1 at accept+5.
- out_ready=0 with ADD 1+2 result pending, new in_valid -> in_ready=0, res=3 held stable; raise out_ready -> the new op is accepted on the same edge.
- SHL a=0xB b=1 -> res=0x06. SHR a=0xB b=2 -> res=0x02. XOR a=0xA b=0xF -> 0x05.
- rst_n pulsed low at MUL cycle 2 -> out_valid=0, busy=0 immediately, no stale result after release. With ALU_PIPE_OVF_EN: ADD 7+1 -> ovf=1.
